ctrl_redirect_arb: RTL and testbench

- Collects resolved control-flow outcomes (branch, JALR) from all control ALU lanes in the execute stage.
- Selects the oldest mispredicting instruction by active-list age.
- Issues a single registered redirect (target PC plus active-list id) to fetch/recovery over a valid/ready handshake.
- Suppresses wrong-path mispredicts that resolve after a redirect has been accepted.

---
 rtl/ctrl_redirect_arb.sv | 176 +++++++++++++++++
 tb/tb_ctrl_redirect_arb.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_redirect_arb.sv
// rtl/ctrl_redirect_arb.sv - oldest-mispredict redirect arbiter with registered valid/ready request.
// Optional performance counters are enabled by defining CTRL_REDIRECT_PERF_EN.
module ctrl_redirect_arb #(
  parameter int NUM_LANES    = 2,
  parameter int AL_IDX_W     = 7,
  parameter int PC_W         = 32,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          flush_i,
  input  logic [AL_IDX_W-1:0]           alHead_i,
  input  logic [NUM_LANES-1:0]          laneValid_i,
  input  logic [NUM_LANES-1:0]          laneMispred_i,
  input  logic [NUM_LANES*AL_IDX_W-1:0] laneAlId_i,
  input  logic [NUM_LANES*PC_W-1:0]     laneNextPC_i,
  output logic                          redirectValid_o,
  input  logic                          redirectReady_i,
  output logic [PC_W-1:0]               redirectPC_o,
  output logic [AL_IDX_W-1:0]           redirectAlId_o,
  output logic                          busy_o
`ifdef CTRL_REDIRECT_PERF_EN
  ,
  output logic [31:0]                   perfRedirects_o,
  output logic [31:0]                   perfReplaced_o,
  output logic [31:0]                   perfDropped_o
`endif
);

  localparam int CNT_W = (DRAIN_CYCLES > 2) ? $clog2(DRAIN_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, HOLD, DRAIN} state_t;

  state_t              state_q, state_d;
  logic [PC_W-1:0]     pc_q, pc_d;
  logic [AL_IDX_W-1:0] id_q, id_d;
  logic [AL_IDX_W-1:0] last_q, last_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic                cand_any;
  logic [AL_IDX_W-1:0] lane_age, best_age, best_id, lane_id;
  logic [PC_W-1:0]     best_pc;
  logic [31:0]         n_cand;
  logic [AL_IDX_W-1:0] held_age, last_age;
  logic                older_held, older_last;
  logic                accept, replace;

  // Oldest candidate by head-relative age; strict compare keeps the lower lane on ties.
  always_comb begin
    cand_any = 1'b0;
    best_age = '0;
    best_id  = '0;
    best_pc  = '0;
    lane_age = '0;
    lane_id  = '0;
    n_cand   = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      lane_id  = laneAlId_i[i*AL_IDX_W +: AL_IDX_W];
      lane_age = lane_id - alHead_i;
      if (laneValid_i[i] && laneMispred_i[i]) begin
        n_cand = n_cand + 32'd1;
        if (!cand_any || (lane_age < best_age)) begin
          cand_any = 1'b1;
          best_age = lane_age;
          best_id  = lane_id;
          best_pc  = laneNextPC_i[i*PC_W +: PC_W];
        end
      end
    end
  end

  assign held_age   = id_q - alHead_i;
  assign last_age   = last_q - alHead_i;
  assign older_held = cand_any && (best_age < held_age);
  assign older_last = cand_any && (best_age < last_age);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    id_d    = id_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    replace = 1'b0;
    if (flush_i) begin
      state_d = IDLE;
      pc_d    = '0;
      id_d    = '0;
      last_d  = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cand_any) begin
            state_d = HOLD;
            pc_d    = best_pc;
            id_d    = best_id;
            accept  = 1'b1;
          end
        end
        HOLD: begin
          if (redirectReady_i) begin
            // The old payload leaves this cycle; an older candidate becomes a fresh request.
            last_d = id_q;
            if (older_held) begin
              pc_d   = best_pc;
              id_d   = best_id;
              accept = 1'b1;
            end else begin
              state_d = DRAIN;
              cnt_d   = CNT_W'(DRAIN_CYCLES - 1);
            end
          end else if (older_held) begin
            pc_d    = best_pc;
            id_d    = best_id;
            accept  = 1'b1;
            replace = 1'b1;
          end
        end
        DRAIN: begin
          if (older_last) begin
            state_d = HOLD;
            pc_d    = best_pc;
            id_d    = best_id;
            accept  = 1'b1;
          end else if (cnt_q == '0) begin
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      pc_q    <= '0;
      id_q    <= '0;
      last_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      id_q    <= id_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  assign redirectValid_o = (state_q == HOLD);
  assign redirectPC_o    = pc_q;
  assign redirectAlId_o  = id_q;
  assign busy_o          = (state_q != IDLE);

`ifdef CTRL_REDIRECT_PERF_EN
  logic [31:0] n_drop;
  assign n_drop = n_cand - {31'd0, accept};

  // A transfer under flush was still taken by the consumer, so it is counted.
  always_ff @(posedge clk) begin
    if (!reset) begin
      perfRedirects_o <= '0;
      perfReplaced_o  <= '0;
      perfDropped_o   <= '0;
    end else begin
      if ((state_q == HOLD) && redirectReady_i) perfRedirects_o <= perfRedirects_o + 32'd1;
      if (replace) perfReplaced_o <= perfReplaced_o + 32'd1;
      if (!flush_i) perfDropped_o <= perfDropped_o + n_drop;
    end
  end
`endif

endmodule

// File: tb/tb_ctrl_redirect_arb.sv
// tb/tb_ctrl_redirect_arb.sv - directed self-checking bench for ctrl_redirect_arb.
module tb_ctrl_redirect_arb;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic [6:0]  al_head;
  logic [1:0]  lane_valid;
  logic [1:0]  lane_mispred;
  logic [13:0] lane_al_id;
  logic [63:0] lane_next_pc;
  logic        redirect_valid;
  logic        redirect_ready;
  logic [31:0] redirect_pc;
  logic [6:0]  redirect_al_id;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  ctrl_redirect_arb dut (
    .clk             (clk),
    .reset           (reset),
    .flush_i         (flush),
    .alHead_i        (al_head),
    .laneValid_i     (lane_valid),
    .laneMispred_i   (lane_mispred),
    .laneAlId_i      (lane_al_id),
    .laneNextPC_i    (lane_next_pc),
    .redirectValid_o (redirect_valid),
    .redirectReady_i (redirect_ready),
    .redirectPC_o    (redirect_pc),
    .redirectAlId_o  (redirect_al_id),
    .busy_o          (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_lanes();
    lane_valid   = '0;
    lane_mispred = '0;
    lane_al_id   = '0;
    lane_next_pc = '0;
  endtask

  task automatic set_lane(input int l, input logic mis, input logic [6:0] id, input logic [31:0] pc);
    lane_valid[l]            = 1'b1;
    lane_mispred[l]          = mis;
    lane_al_id[l*7 +: 7]     = id;
    lane_next_pc[l*32 +: 32] = pc;
  endtask

  task automatic expect_out(input string tag, input logic v, input logic [31:0] pc,
                            input logic [6:0] id, input logic b);
    check({tag, ".valid"}, 64'(redirect_valid), 64'(v));
    if (v) begin
      check({tag, ".pc"}, 64'(redirect_pc), 64'(pc));
      check({tag, ".id"}, 64'(redirect_al_id), 64'(id));
    end
    check({tag, ".busy"}, 64'(busy), 64'(b));
  endtask

  initial begin
    reset = 1'b0;
    flush = 1'b0;
    al_head = '0;
    redirect_ready = 1'b1;
    clear_lanes();
    step();
    step();
    check("reset.valid", 64'(redirect_valid), 64'd0);
    check("reset.pc", 64'(redirect_pc), 64'd0);
    check("reset.id", 64'(redirect_al_id), 64'd0);
    check("reset.busy", 64'(busy), 64'd0);
    reset = 1'b1;
    step();

    // Correct prediction is ignored
    set_lane(0, 1'b0, 7'd3, 32'h900);
    step();
    clear_lanes();
    expect_out("correct_pred", 1'b0, 32'h0, 7'd0, 1'b0);

    // Single mispredict, transfer, 3 drain cycles, idle
    set_lane(0, 1'b1, 7'd5, 32'h1000);
    step();
    clear_lanes();
    expect_out("single.hold", 1'b1, 32'h1000, 7'd5, 1'b1);
    step();
    expect_out("single.drain0", 1'b0, 32'h0, 7'd0, 1'b1);
    step();
    expect_out("single.drain1", 1'b0, 32'h0, 7'd0, 1'b1);
    step();
    expect_out("single.drain2", 1'b0, 32'h0, 7'd0, 1'b1);
    step();
    expect_out("single.idle", 1'b0, 32'h0, 7'd0, 1'b0);

    // Two lanes in the same cycle: the older id on lane1 wins
    redirect_ready = 1'b0;
    set_lane(0, 1'b1, 7'd9, 32'h2000);
    set_lane(1, 1'b1, 7'd4, 32'h3000);
    step();
    clear_lanes();
    expect_out("two_lanes", 1'b1, 32'h3000, 7'd4, 1'b1);
    redirect_ready = 1'b1;
    repeat (4) step();
    expect_out("two_lanes.idle", 1'b0, 32'h0, 7'd0, 1'b0);

    // Replacement while held, later younger candidate dropped
    redirect_ready = 1'b0;
    set_lane(0, 1'b1, 7'd20, 32'h20);
    step();
    clear_lanes();
    expect_out("repl.first", 1'b1, 32'h20, 7'd20, 1'b1);
    set_lane(1, 1'b1, 7'd12, 32'h12);
    step();
    clear_lanes();
    expect_out("repl.older", 1'b1, 32'h12, 7'd12, 1'b1);
    set_lane(0, 1'b1, 7'd30, 32'h30);
    step();
    clear_lanes();
    expect_out("repl.younger_dropped", 1'b1, 32'h12, 7'd12, 1'b1);
    redirect_ready = 1'b1;
    step();
    expect_out("repl.xfer", 1'b0, 32'h0, 7'd0, 1'b1);
    repeat (3) step();
    expect_out("repl.idle", 1'b0, 32'h0, 7'd0, 1'b0);

    // Wrap-around: head 126, id 127 older than id 1
    al_head = 7'd126;
    redirect_ready = 1'b0;
    set_lane(0, 1'b1, 7'd1, 32'h111);
    set_lane(1, 1'b1, 7'd127, 32'h7f7f);
    step();
    clear_lanes();
    expect_out("wrap", 1'b1, 32'h7f7f, 7'd127, 1'b1);
    redirect_ready = 1'b1;
    repeat (4) step();
    expect_out("wrap.idle", 1'b0, 32'h0, 7'd0, 1'b0);
    al_head = 7'd0;

    // Equal age on both lanes: lane0 wins
    redirect_ready = 1'b0;
    set_lane(0, 1'b1, 7'd70, 32'haaaa);
    set_lane(1, 1'b1, 7'd70, 32'hbbbb);
    step();
    clear_lanes();
    expect_out("tie", 1'b1, 32'haaaa, 7'd70, 1'b1);
    redirect_ready = 1'b1;
    repeat (4) step();
    expect_out("tie.idle", 1'b0, 32'h0, 7'd0, 1'b0);

    // Drain filtering: 41 discarded after 40, 38 restarts a redirect
    set_lane(0, 1'b1, 7'd40, 32'h4000);
    step();
    clear_lanes();
    expect_out("drain.hold40", 1'b1, 32'h4000, 7'd40, 1'b1);
    step();
    expect_out("drain.xfer40", 1'b0, 32'h0, 7'd0, 1'b1);
    set_lane(0, 1'b1, 7'd41, 32'h4100);
    step();
    clear_lanes();
    expect_out("drain.drop41", 1'b0, 32'h0, 7'd0, 1'b1);
    redirect_ready = 1'b0;
    set_lane(1, 1'b1, 7'd38, 32'h3800);
    step();
    clear_lanes();
    expect_out("drain.hold38", 1'b1, 32'h3800, 7'd38, 1'b1);

    // Flush in hold with ready low; lane inputs during flush ignored
    flush = 1'b1;
    set_lane(0, 1'b1, 7'd3, 32'h333);
    step();
    clear_lanes();
    flush = 1'b0;
    expect_out("flush", 1'b0, 32'h0, 7'd0, 1'b0);
    check("flush.pc", 64'(redirect_pc), 64'd0);
    check("flush.id", 64'(redirect_al_id), 64'd0);
    step();
    expect_out("flush.after", 1'b0, 32'h0, 7'd0, 1'b0);

    // Transfer coinciding with an older candidate stays in hold with the new payload
    set_lane(0, 1'b1, 7'd60, 32'h6000);
    step();
    clear_lanes();
    expect_out("xfer_repl.hold60", 1'b1, 32'h6000, 7'd60, 1'b1);
    redirect_ready = 1'b1;
    set_lane(1, 1'b1, 7'd55, 32'h5500);
    step();
    clear_lanes();
    expect_out("xfer_repl.hold55", 1'b1, 32'h5500, 7'd55, 1'b1);
    step();
    expect_out("xfer_repl.drain", 1'b0, 32'h0, 7'd0, 1'b1);
    set_lane(0, 1'b1, 7'd58, 32'h5800);
    step();
    clear_lanes();
    expect_out("xfer_repl.drop58", 1'b0, 32'h0, 7'd0, 1'b1);
    repeat (2) step();
    expect_out("xfer_repl.idle", 1'b0, 32'h0, 7'd0, 1'b0);

    // Reset mid-hold
    redirect_ready = 1'b0;
    set_lane(0, 1'b1, 7'd50, 32'h5000);
    step();
    clear_lanes();
    expect_out("rst_hold", 1'b1, 32'h5000, 7'd50, 1'b1);
    reset = 1'b0;
    step();
    reset = 1'b1;
    check("rst_mid.valid", 64'(redirect_valid), 64'd0);
    check("rst_mid.pc", 64'(redirect_pc), 64'd0);
    check("rst_mid.id", 64'(redirect_al_id), 64'd0);
    check("rst_mid.busy", 64'(busy), 64'd0);
    step();
    expect_out("rst_mid.after", 1'b0, 32'h0, 7'd0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
